sipo_led_rx: RTL and testbench

Serial-to-parallel receiver for the 16-bit LED serial link. It sits at the far end of the link from the LED serializer and rebuilds the 16-bit LED word from the serial data line and the active-low latch strobe. It also checks frame length, reports and counts malformed frames, and presents the last good word on a registered parallel bus for the LED drivers.

---
 rtl/sipo_led_rx.sv | 99 +++++++++
 tb/tb_sipo_led_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_led_rx.sv
// Serial-to-parallel LED link receiver with frame length checking.
// Optional SIPO_LED_UNSWAP_EN undoes the transmitter byte swap on led_out.
module sipo_led_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdata,
  input  logic        latch,
  output logic [15:0] led_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        synced
);

  typedef enum logic {
    HUNT,
    SHIFT
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVR  = 5'd17;

  state_t      state, state_nx;
  logic [15:0] shreg, shreg_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [15:0] led_nx;
  logic [15:0] word;
  logic        fv_nx;
  logic        fe_nx;
  logic [7:0]  err_nx;
  logic        sync_nx;

`ifdef SIPO_LED_UNSWAP_EN
  assign word = {shreg[7:0], shreg[15:8]};
`else
  assign word = shreg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shreg       <= '0;
      cnt         <= '0;
      led_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      synced      <= 1'b0;
    end else begin
      state       <= state_nx;
      shreg       <= shreg_nx;
      cnt         <= cnt_nx;
      led_out     <= led_nx;
      frame_valid <= fv_nx;
      frame_err   <= fe_nx;
      err_cnt     <= err_nx;
      synced      <= sync_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    led_nx   = led_out;
    fv_nx    = 1'b0;
    fe_nx    = 1'b0;
    err_nx   = err_cnt;
    sync_nx  = synced;
    unique case (state)
      HUNT: begin
        if (!latch) begin
          state_nx = SHIFT;
          sync_nx  = 1'b1;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (latch) begin
          shreg_nx = {sdata, shreg[15:1]};
          if (cnt != CNT_OVR)
            cnt_nx = cnt + 5'd1;
        end else begin
          cnt_nx = '0;
          if (cnt == CNT_FULL) begin
            led_nx = word;
            fv_nx  = 1'b1;
          end else begin
            fe_nx = 1'b1;
            if (err_cnt != 8'hFF)
              err_nx = err_cnt + 8'd1;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

endmodule

// File: tb/tb_sipo_led_rx.sv
// Directed bench for sipo_led_rx: vector table plus reset,
// sync and saturation sequences.
module tb_sipo_led_rx;

  logic        clk;
  logic        rst_n;
  logic        sdata;
  logic        latch;
  logic [15:0] led_out;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        synced;

  int n_cmp;
  int n_err;
  int fv_seen;
  int fe_seen;
  int cyc_n;
  int last_fv;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        exp_fv;
    logic        exp_fe;
    logic [15:0] exp_wire;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  sipo_led_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sdata       (sdata),
    .latch       (latch),
    .led_out     (led_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .synced      (synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_led(input logic [15:0] w);
`ifdef SIPO_LED_UNSWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic l);
    @(negedge clk);
    sdata = s;
    latch = l;
    @(posedge clk);
    #1;
    cyc_n++;
    if (frame_valid) fv_seen++;
    if (frame_err) fe_seen++;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n,
                           input int start);
    for (int i = 0; i < n; i++)
      cyc(w[(start + i) % 16], 1'b1);
  endtask

  initial begin
    logic [15:0] led_hold;
    n_cmp   = 0;
    n_err   = 0;
    fv_seen = 0;
    fe_seen = 0;
    cyc_n   = 0;
    last_fv = 0;
    rst_n   = 1'b0;
    sdata   = 1'b0;
    latch   = 1'b1;

    vecs[0] = '{16'hA5C3, 16, 1'b1, 1'b0, 16'hA5C3, 8'd2};
    vecs[1] = '{16'h1234, 10, 1'b0, 1'b1, 16'hA5C3, 8'd3};
    vecs[2] = '{16'h1234, 16, 1'b1, 1'b0, 16'h1234, 8'd3};
    vecs[3] = '{16'hFFFF, 20, 1'b0, 1'b1, 16'h1234, 8'd4};
    vecs[4] = '{16'h0001, 16, 1'b1, 1'b0, 16'h0001, 8'd4};
    vecs[5] = '{16'h8000, 16, 1'b1, 1'b0, 16'h8000, 8'd4};
    vecs[6] = '{16'hFFFF, 16, 1'b1, 1'b0, 16'hFFFF, 8'd4};

    repeat (2) @(posedge clk);
    #1;
    check("rst_led", led_out, 16'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_cnt", err_cnt, 8'h0);
    check("rst_sync", synced, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);
    check("hunt_sync", synced, 1'b0);
    cyc(1'b0, 1'b0);
    check("sync1", synced, 1'b1);
    check("sync1_fe", frame_err, 1'b0);
    cyc(1'b0, 1'b0);
    check("dbl_fe2", frame_err, 1'b1);
    cyc(1'b0, 1'b0);
    check("dbl_fe3", frame_err, 1'b1);
    check("dbl_cnt", err_cnt, 8'd2);
    check("dbl_led", led_out, 16'h0);

    for (int i = 0; i < 7; i++) begin
      fv_seen = 0;
      fe_seen = 0;
      send_bits(vecs[i].word, vecs[i].nbits, 0);
      check($sformatf("v%0d_stray", i), fv_seen + fe_seen, 0);
      cyc(1'b0, 1'b0);
      check($sformatf("v%0d_fv", i), frame_valid, vecs[i].exp_fv);
      check($sformatf("v%0d_fe", i), frame_err, vecs[i].exp_fe);
      check($sformatf("v%0d_led", i), led_out,
            exp_led(vecs[i].exp_wire));
      check($sformatf("v%0d_cnt", i), err_cnt, vecs[i].exp_cnt);
      if (i >= 5)
        check($sformatf("v%0d_period", i), cyc_n - last_fv, 17);
      if (frame_valid) last_fv = cyc_n;
    end

    led_hold = led_out;
    fe_seen  = 0;
    fv_seen  = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
    end
    check("sat_pulses", fe_seen, 300);
    check("sat_fv", fv_seen, 0);
    check("sat_cnt", err_cnt, 8'hFF);
    check("sat_led", led_out, led_hold);

    send_bits(16'hFFFF, 8, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led", led_out, 16'h0);
    check("async_cnt", err_cnt, 8'h0);
    check("async_sync", synced, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fv_seen = 0;
    fe_seen = 0;
    send_bits(16'h0F0F, 8, 8);
    check("resync_quiet", fv_seen + fe_seen, 0);
    check("resync_hunt", synced, 1'b0);
    cyc(1'b0, 1'b0);
    check("resync_sync", synced, 1'b1);
    check("resync_nopulse", frame_valid | frame_err, 1'b0);
    check("resync_led0", led_out, 16'h0);
    send_bits(16'h0F0F, 16, 0);
    cyc(1'b0, 1'b0);
    check("resync_fv", frame_valid, 1'b1);
    check("resync_led", led_out, exp_led(16'h0F0F));
    check("resync_cnt", err_cnt, 8'h0);
    check("resync_fe_total", fe_seen, 0);
    cyc(1'b1, 1'b1);
    check("fv_one_cycle", frame_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
